// File: rtl/namuru_snapshot.sv
// namuru_snapshot: raw 2-bit sign/mag sample capture buffer.
// A CSR start packs decimated samples 16-per-word into an internal RAM,
// pulses irq when the requested number of words is stored, and the CPU
// reads the packed words back through the CSR window at 0x200.
// CSR access: a write takes effect on the sys_clk edge where csr_we is high
// and the block is selected; every selected address is read with a
// one-cycle registered latency, unselected cycles read 0.
module namuru_snapshot #(
  parameter logic [3:0] csr_addr   = 4'h0,
  parameter int         depth_log2 = 9
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  input  logic        sample_stb,
  input  logic        gps_sign,
  input  logic        gps_mag,
  output logic        irq
);

  localparam int cw = depth_log2 + 1;
  localparam int words = 1 << depth_log2;
  localparam logic [cw-1:0] max_len = cw'(words);

  typedef enum logic [1:0] {st_idle, st_capture, st_done} state_t;
  state_t state, state_nxt;

  logic [31:0]   ram [0:words-1];
  logic [cw-1:0] length, len_lat, count;
  logic [7:0]    decim, dec_lat, dec_cnt;
  logic [31:0]   pack;
  logic [3:0]    pack_idx;
  logic          wr_pend, done;

  logic          sel, wr_ctrl, start_cmd, abort_cmd, clear_cmd;
  logic          begin_cap, take_sample, write_word;
  logic [9:0]    off;
  logic [8:0]    buf_off;
  logic          buf_hit;
  logic          unused_di;

  assign sel       = (csr_a[13:10] == csr_addr);
  assign off       = csr_a[9:0];
  assign buf_off   = csr_a[8:0];
  assign buf_hit   = off[9] && ((buf_off >> depth_log2) == 9'd0);
  assign wr_ctrl   = sel && csr_we && (off == 10'h000);
  assign start_cmd = wr_ctrl && csr_di[0];
  assign abort_cmd = wr_ctrl && csr_di[1];
  assign clear_cmd = wr_ctrl && csr_di[2];
  assign unused_di = ^csr_di[31:10];

  assign irq = (state == st_done);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= st_idle;
    else         state <= state_nxt;
  end

  // Next-state logic and per-cycle datapath controls; abort overrides start.
  always_comb begin
    state_nxt   = state;
    begin_cap   = 1'b0;
    take_sample = 1'b0;
    write_word  = 1'b0;
    case (state)
      st_idle: begin
        if (start_cmd && !abort_cmd && (length != '0)) begin
          state_nxt = st_capture;
          begin_cap = 1'b1;
        end
      end
      st_capture: begin
        if (abort_cmd) begin
          state_nxt = st_idle;
        end else begin
          take_sample = sample_stb && (dec_cnt == 8'd0);
          write_word  = wr_pend;
          if (wr_pend && ((count + cw'(1)) == len_lat)) state_nxt = st_done;
        end
      end
      st_done:  state_nxt = st_idle;
      default:  state_nxt = st_idle;
    endcase
  end

  // Config registers, capture counters, sample packing and done flag.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      length   <= '0;
      decim    <= '0;
      len_lat  <= '0;
      dec_lat  <= '0;
      count    <= '0;
      dec_cnt  <= '0;
      pack     <= '0;
      pack_idx <= '0;
      wr_pend  <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (sel && csr_we && (off == 10'h001)) length <= csr_di[cw-1:0];
      if (sel && csr_we && (off == 10'h003)) decim  <= csr_di[7:0];
      if (clear_cmd) done <= 1'b0;
      if (begin_cap) begin
        len_lat  <= (length > max_len) ? max_len : length;
        dec_lat  <= decim;
        count    <= '0;
        dec_cnt  <= '0;
        pack     <= '0;
        pack_idx <= '0;
        wr_pend  <= 1'b0;
        done     <= 1'b0;
      end
      if (write_word) begin
        count   <= count + cw'(1);
        wr_pend <= 1'b0;
      end
      // New samples enter at the top so sample 0 ends up in bits [1:0].
      if (take_sample) begin
        pack     <= {gps_sign, gps_mag, pack[31:2]};
        dec_cnt  <= dec_lat;
        pack_idx <= pack_idx + 4'd1;
        if (pack_idx == 4'd15) wr_pend <= 1'b1;
      end else if ((state == st_capture) && sample_stb && (dec_cnt != 8'd0)) begin
        dec_cnt <= dec_cnt - 8'd1;
      end
      if ((state == st_capture) && (state_nxt == st_done)) done <= 1'b1;
    end
  end

  // Sample buffer write port; contents are not affected by reset.
  always_ff @(posedge sys_clk) begin
    if (write_word) ram[count[depth_log2-1:0]] <= pack;
  end

  // Registered CSR read mux.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || !sel) begin
      csr_do <= '0;
    end else begin
      case (off)
        10'h000: csr_do <= {30'd0, done, (state == st_capture)};
        10'h001: csr_do <= 32'(length);
        10'h002: csr_do <= 32'(count);
        10'h003: csr_do <= {24'd0, decim};
        default: csr_do <= buf_hit ? ram[csr_a[depth_log2-1:0]] : 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_namuru_snapshot.sv
// Testbench for namuru_snapshot: randomized sample streams checked against
// a queue-based packing model built from the capture rules.
module tb_namuru_snapshot;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [13:0] csr_a = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = '0;
  logic [31:0] csr_do;
  logic        sample_stb = 1'b0;
  logic        gps_sign = 1'b0;
  logic        gps_mag = 1'b0;
  logic        irq;

  namuru_snapshot dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do),
    .sample_stb(sample_stb), .gps_sign(gps_sign), .gps_mag(gps_mag),
    .irq(irq)
  );

  localparam logic [13:0] a_ctrl = 14'h0000;
  localparam logic [13:0] a_len  = 14'h0001;
  localparam logic [13:0] a_cnt  = 14'h0002;
  localparam logic [13:0] a_dec  = 14'h0003;
  localparam logic [13:0] a_buf  = 14'h0200;

  int vec_cnt = 0;
  int err_cnt = 0;
  int irq_cnt = 0;
  int irq_base;

  logic [1:0]  smp_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] rd;

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // Count irq cycles just after each rising edge.
  always @(posedge sys_clk) begin
    #1;
    if (irq) irq_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drivers: every task starts and ends just after a falling edge.
  task automatic csr_write(input logic [13:0] a, input logic [31:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [13:0] a, output logic [31:0] d);
    csr_a = a; csr_we = 1'b0;
    @(negedge sys_clk);
    d = csr_do;
  endtask

  task automatic reg_chk(input string tag, input logic [13:0] a, input logic [31:0] exp);
    logic [31:0] v;
    csr_read(a, v);
    check(tag, v, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_range(input int lo, input int hi, input int max_gap);
    for (int i = lo; i < hi; i++) begin
      sample_stb = 1'b1;
      {gps_sign, gps_mag} = smp_q[i];
      @(negedge sys_clk);
      sample_stb = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge sys_clk);
    end
  endtask

  // Reference: keep every (dec+1)-th strobe starting with the first, pack
  // 16 kept samples per word LSB-first, stop after len words.
  task automatic build_expected(input int len, input int dec);
    logic [31:0] w;
    int k;
    exp_q.delete();
    w = 0;
    k = 0;
    foreach (smp_q[i]) begin
      if ((i % (dec + 1) == 0) && (exp_q.size() < len)) begin
        w = w | (32'(smp_q[i]) << (2 * k));
        k++;
        if (k == 16) begin
          exp_q.push_back(w);
          w = 0;
          k = 0;
        end
      end
    end
  endtask

  task automatic check_words(input string tag, input int len);
    for (int i = 0; i < len; i++) reg_chk(tag, a_buf + 14'(i), exp_q[i]);
  endtask

  initial begin
    int len, dec;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;

    // Reset state.
    reg_chk("rst_ctrl", a_ctrl, 32'd0);
    reg_chk("rst_len", a_len, 32'd0);
    reg_chk("rst_cnt", a_cnt, 32'd0);
    reg_chk("rst_dec", a_dec, 32'd0);
    check("rst_irq", 32'(irq_cnt), 32'd0);

    // Two words of constant 2'b10.
    smp_q.delete();
    repeat (32) smp_q.push_back(2'b10);
    build_expected(2, 0);
    csr_write(a_len, 32'd2);
    csr_write(a_dec, 32'd0);
    irq_base = irq_cnt;
    csr_write(a_ctrl, 32'd1);
    drive_range(0, 32, 0);
    idle(6);
    check("t1_irq", 32'(irq_cnt - irq_base), 32'd1);
    reg_chk("t1_ctrl", a_ctrl, 32'd2);
    reg_chk("t1_cnt", a_cnt, 32'd2);
    check_words("t1_word", 2);
    check("t1_const", exp_q[0], 32'hAAAAAAAA);

    // 0,1,2,3 pattern, read latency and block select.
    smp_q.delete();
    for (int i = 0; i < 20; i++) smp_q.push_back(2'(i));
    build_expected(1, 0);
    csr_write(a_len, 32'd1);
    csr_write(a_ctrl, 32'd1);
    drive_range(0, 20, 2);
    idle(6);
    check("t2_const", exp_q[0], 32'hE4E4E4E4);
    csr_a = {4'h1, 10'h200};
    @(negedge sys_clk);
    check("t2_other_blk", csr_do, 32'd0);
    csr_a = a_buf;
    #1;
    check("t2_lat_before", csr_do, 32'd0);
    @(negedge sys_clk);
    check("t2_lat_after", csr_do, exp_q[0]);
    csr_write(a_ctrl, 32'd4);
    reg_chk("t2_clear_done", a_ctrl, 32'd0);

    // Decimation by 4; irq must follow the 61st strobe.
    smp_q.delete();
    for (int i = 0; i < 64; i++) smp_q.push_back((i % 4 == 0) ? 2'b11 : 2'b00);
    build_expected(1, 3);
    csr_write(a_dec, 32'd3);
    csr_write(a_len, 32'd1);
    irq_base = irq_cnt;
    csr_write(a_ctrl, 32'd1);
    drive_range(0, 60, 0);
    idle(5);
    check("t3_no_irq_yet", 32'(irq_cnt - irq_base), 32'd0);
    drive_range(60, 61, 0);
    idle(5);
    check("t3_irq", 32'(irq_cnt - irq_base), 32'd1);
    drive_range(61, 64, 0);
    idle(3);
    check("t3_irq_once", 32'(irq_cnt - irq_base), 32'd1);
    reg_chk("t3_word", a_buf, exp_q[0]);
    check("t3_const", exp_q[0], 32'hFFFFFFFF);

    // Randomized captures.
    for (int it = 0; it < 4; it++) begin
      len = $urandom_range(1, 4);
      dec = $urandom_range(0, 3);
      smp_q.delete();
      repeat (len * 16 * (dec + 1) + $urandom_range(0, 5)) smp_q.push_back(2'($urandom_range(0, 3)));
      build_expected(len, dec);
      csr_write(a_len, 32'(len));
      csr_write(a_dec, 32'(dec));
      irq_base = irq_cnt;
      csr_write(a_ctrl, 32'd1);
      // Config changes mid-capture must not affect the running capture.
      csr_write(a_len, 32'd7);
      csr_write(a_dec, 32'd9);
      drive_range(0, smp_q.size(), 2);
      idle(6);
      check("rnd_irq", 32'(irq_cnt - irq_base), 32'd1);
      reg_chk("rnd_ctrl", a_ctrl, 32'd2);
      reg_chk("rnd_cnt", a_cnt, 32'(len));
      reg_chk("rnd_len_rb", a_len, 32'd7);
      check_words("rnd_word", len);
    end

    // Abort mid-capture.
    smp_q.delete();
    repeat (40) smp_q.push_back(2'($urandom_range(0, 3)));
    csr_write(a_len, 32'd4);
    csr_write(a_dec, 32'd0);
    irq_base = irq_cnt;
    csr_write(a_ctrl, 32'd1);
    drive_range(0, 40, 0);
    idle(3);
    csr_write(a_ctrl, 32'd2);
    idle(3);
    reg_chk("t4_ctrl", a_ctrl, 32'd0);
    reg_chk("t4_cnt", a_cnt, 32'd2);
    check("t4_no_irq", 32'(irq_cnt - irq_base), 32'd0);
    csr_write(a_ctrl, 32'd1);
    reg_chk("t4_restart_cnt", a_cnt, 32'd0);
    reg_chk("t4_restart_busy", a_ctrl, 32'd1);
    csr_write(a_ctrl, 32'd3);
    reg_chk("t4_abort2", a_ctrl, 32'd0);

    // LENGTH=0 start is a no-op; start+abort together stays idle.
    csr_write(a_len, 32'd0);
    csr_write(a_ctrl, 32'd1);
    reg_chk("t5_len0", a_ctrl, 32'd0);
    csr_write(a_len, 32'd3);
    csr_write(a_ctrl, 32'd3);
    reg_chk("t5_start_abort", a_ctrl, 32'd0);
    reg_chk("t5_unmapped", 14'h0004, 32'd0);

    // Oversized LENGTH clamps to the 512-word buffer.
    smp_q.delete();
    repeat (8192 + 16) smp_q.push_back(2'($urandom_range(0, 3)));
    build_expected(512, 0);
    csr_write(a_len, 32'd1023);
    reg_chk("t5_len_rb", a_len, 32'd1023);
    irq_base = irq_cnt;
    csr_write(a_ctrl, 32'd1);
    drive_range(0, smp_q.size(), 0);
    idle(6);
    check("t5_irq", 32'(irq_cnt - irq_base), 32'd1);
    reg_chk("t5_cnt", a_cnt, 32'd512);
    reg_chk("t5_ctrl", a_ctrl, 32'd2);
    reg_chk("t5_w0", a_buf, exp_q[0]);
    reg_chk("t5_w1", a_buf + 14'd1, exp_q[1]);
    reg_chk("t5_w511", a_buf + 14'd511, exp_q[511]);

    // Reset during capture.
    smp_q.delete();
    repeat (20) smp_q.push_back(2'($urandom_range(0, 3)));
    csr_write(a_len, 32'd2);
    irq_base = irq_cnt;
    csr_write(a_ctrl, 32'd1);
    drive_range(0, 20, 0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    idle(10);
    reg_chk("t6_ctrl", a_ctrl, 32'd0);
    reg_chk("t6_cnt", a_cnt, 32'd0);
    reg_chk("t6_len", a_len, 32'd0);
    check("t6_no_irq", 32'(irq_cnt - irq_base), 32'd0);

    // A strobe on the start cycle is not captured.
    smp_q.delete();
    repeat (16) smp_q.push_back(2'b01);
    build_expected(1, 0);
    csr_write(a_len, 32'd1);
    csr_a = a_ctrl; csr_di = 32'd1; csr_we = 1'b1;
    sample_stb = 1'b1; {gps_sign, gps_mag} = 2'b11;
    @(negedge sys_clk);
    csr_we = 1'b0; sample_stb = 1'b0;
    drive_range(0, 16, 1);
    idle(6);
    reg_chk("t6_coinc_word", a_buf, exp_q[0]);
    check("t6_const", exp_q[0], 32'h55555555);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/namuru_snapshot.md
Name: namuru_snapshot

Overview:
Raw front-end sample capture buffer for software acquisition. Sits directly upstream of the correlator, tapping the same 2-bit sign/mag sample stream. On a CSR start command it packs N decimated samples into 32-bit words in an internal RAM, then raises an interrupt. The CPU reads the packed words back over the CSR bus for FFT-based acquisition before handing a channel to the correlator.

Parameters:
csr_addr, 4'h0, CSR block select matched against csr_a[13:10]
depth_log2, 9, log2 of buffer depth in 32-bit words (max 9; 512 words = 8192 samples)

Ports:
sys_clk  in  1  system clock; all logic is on this single clock
sys_rst  in  1  synchronous, active-high reset
csr_a  in  14  CSR address
csr_we  in  1  CSR write strobe
csr_di  in  32  CSR write data
csr_do  out  32  CSR read data, registered
sample_stb  in  1  one-cycle strobe: gps_sign/gps_mag valid this cycle (already in sys_clk domain)
gps_sign  in  1  sample sign bit
gps_mag  in  1  sample magnitude bit
irq  out  1  one-cycle pulse when a capture completes

Behaviour:
- Block is selected when csr_a[13:10]==csr_addr. Word offset is csr_a[9:0]. csr_do is 0 when not selected. Read latency is 1 cycle.
- Register map:
  - 0x000 CTRL
    - W: bit0 start, bit1 abort, bit2 clear_done.
    - R: bit0 busy, bit1 done, others 0.
  - 0x001 LENGTH (RW, depth_log2+1 bits): words to capture. 0 makes start a no-op. Values >2^depth_log2 are clamped to 2^depth_log2 at start.
  - 0x002 COUNT (RO): words written in the current/last capture.
  - 0x003 DECIM (RW, 8 bits): capture one sample every DECIM+1 strobes.
  - 0x200+i (RO): buffer word i, for i<2^depth_log2. Indices beyond depth read 0.
- Reset: state IDLE, csr_do=0, irq=0, done=0, COUNT=0, LENGTH=0, DECIM=0, pack register and counters 0. RAM contents are undefined.
- FSM states:
  - IDLE:
    - start with LENGTH!=0 → CAPTURE. On that transition: COUNT:=0, pack index:=0, decimation counter:=0, done:=0.
  - CAPTURE (busy=1):
    - On sample_stb with decimation counter==0, shift {gps_sign,gps_mag} into the pack register and reload the counter with DECIM. Other strobes decrement the counter.
    - Packing: sample k of a word lands in bits [2k+1:2k], k=0..15, LSB first, sign in the upper bit.
    - When the 16th sample is taken, the word is written to RAM[COUNT] on the next edge and COUNT increments.
    - COUNT reaching the clamped length → DONE.
  - DONE:
    - done:=1, irq pulses high for exactly one cycle, then → IDLE.
- Control priority and corner cases:
  - abort in CAPTURE → IDLE the next cycle. The partial word is discarded, COUNT is frozen, done stays 0, no irq.
  - abort and start in the same write: abort wins.
  - start while busy is ignored.
  - A sample_stb in the same cycle as the start write is not captured.
  - clear_done clears the done bit. A start also clears done.
  - LENGTH/DECIM writes during CAPTURE update the registers, but the active capture keeps its latched length and decimation.
- Buffer reads during CAPTURE return current RAM contents; no stall.
- sys_rst mid-capture returns to IDLE with no irq. RAM is not cleared.
- The RAM is inferred as a single-port block RAM, or as dual-port with one write and one read port.

Test Plan:
1. Reset, LENGTH=2, DECIM=0, start, 32 strobes with {sign,mag}=2'b10 → irq once, done=1, COUNT=2, buffer words 0 and 1 both read 0xAAAAAAAA.
2. Pattern test: LENGTH=1, DECIM=0, samples 0,1,2,3 repeating → word0=0xE4E4E4E4, one-cycle csr_do latency, csr_do=0 for another csr_addr.
3. Decimation: DECIM=3, LENGTH=1, 64 strobes with sample index i carrying 2'b11 only when i%4==0 (others 2'b00) → word0=0xFFFFFFFF, irq after the 61st strobe's capture.
4. Abort mid-capture: LENGTH=4, 40 strobes, abort → busy=0, done=0, COUNT=2, no irq. A new start restarts COUNT at 0.
5. Corner cases: LENGTH=0 start → stays IDLE. LENGTH=1023 with depth_log2=9 → capture stops at COUNT=512. start+abort in the same write → IDLE.
6. sys_rst asserted during CAPTURE → busy=0, done=0, COUNT=0, irq never pulses. Strobe coincident with start is excluded from word0.
